// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and defaults for the LFSR sequencing controller.
// The FSM state enum, default widths and the all-zero seed substitute.
package lfsr_ctrl_pkg;

    localparam int unsigned DefaultW    = 8;
    localparam int unsigned DefaultCntW = 16;
    localparam logic [7:0]  DefaultZeroSub = 8'h01;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPause,
        StRun,
        StStep
    } state_e;

endpackage

// File: rtl/lfsr_period_mon.sv
// Watches the LFSR one cycle after each shift: captures the sequence period on the first
// return to the seed and flags the all-zero lock-up state.
module lfsr_period_mon #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             lfsr_en,
    input  logic [W-1:0]     lfsr_q,
    input  logic [W-1:0]     seed,
    input  logic [CNT_W-1:0] step_cnt,
    input  logic             step_sat,
    output logic             lock_now,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lock_err
);

    logic             shifted_q;
    logic [CNT_W-1:0] period_q;
    logic             period_valid_q;
    logic             lock_err_q;
    logic             capture;

    // lfsr_q and step_cnt already reflect the shift while shifted_q is high
    assign lock_now = shifted_q && (lfsr_q == '0);
    assign capture  = shifted_q && !period_valid_q && (lfsr_q == seed) && !step_sat;

    always_ff @(posedge clk) begin
        if (rst) begin
            shifted_q      <= 1'b0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            lock_err_q     <= 1'b0;
        end else begin
            shifted_q <= lfsr_en;
            if (clr) begin
                period_q       <= '0;
                period_valid_q <= 1'b0;
                lock_err_q     <= 1'b0;
            end else begin
                if (capture) begin
                    period_q       <= step_cnt;
                    period_valid_q <= 1'b1;
                end
                if (lock_now) begin
                    lock_err_q <= 1'b1;
                end
            end
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign lock_err     = lock_err_q;

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for the 8-bit Fibonacci LFSR: seed load, run/pause, single-step on the divided
// tick, saturating shift counter, and period / lock-up monitoring.
module lfsr_seq_ctrl
    import lfsr_ctrl_pkg::*;
#(
    parameter int unsigned     W        = DefaultW,
    parameter int unsigned     CNT_W    = DefaultCntW,
    parameter logic [W-1:0]    ZERO_SUB = W'(DefaultZeroSub)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_load,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic [W-1:0]     sw,
    input  logic [W-1:0]     lfsr_q,
    output logic             lfsr_load,
    output logic [W-1:0]     lfsr_seed,
    output logic             lfsr_en,
    output logic             running,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             lock_err
);

    state_e           state_q, state_d;
    logic [W-1:0]     seed_q;
    logic [CNT_W-1:0] step_cnt_q;
    logic             step_sat;
    logic             lock_now;
    logic             lock_block;
    logic             shift_ok;

    assign step_sat   = &step_cnt_q;
    assign lock_block = lock_err | lock_now;
    // A coinciding load, reset or lock-up suppresses the shift
    assign shift_ok   = tick && !btn_load && !rst && !lock_now;

    always_comb begin
        state_d = state_q;
        lfsr_en = 1'b0;
        case (state_q)
            StIdle: ;
            StLoad: state_d = StPause;
            StPause: begin
                if (!lock_block) begin
                    if (btn_run) begin
                        state_d = StRun;
                    end else if (btn_step) begin
                        state_d = StStep;
                    end
                end
            end
            StRun: begin
                lfsr_en = shift_ok;
                if (lock_now || btn_run) begin
                    state_d = StPause;
                end
            end
            StStep: begin
                lfsr_en = shift_ok;
                if (lock_now || tick) begin
                    state_d = StPause;
                end
            end
            default: state_d = StIdle;
        endcase
        if (btn_load) begin
            state_d = StLoad;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            seed_q     <= ZERO_SUB;
            step_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (btn_load) begin
                seed_q <= (sw == '0) ? ZERO_SUB : sw;
            end
            if (state_q == StLoad) begin
                step_cnt_q <= '0;
            end else if (lfsr_en && !step_sat) begin
                step_cnt_q <= step_cnt_q + 1'b1;
            end
        end
    end

    lfsr_period_mon #(
        .W     (W),
        .CNT_W (CNT_W)
    ) u_period_mon (
        .clk          (clk),
        .rst          (rst),
        .clr          (state_q == StLoad),
        .lfsr_en      (lfsr_en),
        .lfsr_q       (lfsr_q),
        .seed         (seed_q),
        .step_cnt     (step_cnt_q),
        .step_sat     (step_sat),
        .lock_now     (lock_now),
        .period       (period),
        .period_valid (period_valid),
        .lock_err     (lock_err)
    );

    assign lfsr_load = (state_q == StLoad);
    assign lfsr_seed = seed_q;
    assign running   = (state_q == StRun);
    assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl: stimulus queues expected load/shift pulses, a negedge
// monitor pops and checks them; a behavioural LFSR closes the loop on lfsr_q.
module tb_lfsr_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic        btn_load;
    logic        btn_run;
    logic        btn_step;
    logic [7:0]  sw;
    logic [7:0]  lfsr_q;
    logic        lfsr_load;
    logic [7:0]  lfsr_seed;
    logic        lfsr_en;
    logic        running;
    logic [15:0] step_cnt;
    logic [15:0] period;
    logic        period_valid;
    logic        lock_err;

    typedef struct {
        bit          is_load;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;
    logic [7:0] model;
    logic       force_zero;

    always #5 clk = ~clk;

    lfsr_seq_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .btn_load     (btn_load),
        .btn_run      (btn_run),
        .btn_step     (btn_step),
        .sw           (sw),
        .lfsr_q       (lfsr_q),
        .lfsr_load    (lfsr_load),
        .lfsr_seed    (lfsr_seed),
        .lfsr_en      (lfsr_en),
        .running      (running),
        .step_cnt     (step_cnt),
        .period       (period),
        .period_valid (period_valid),
        .lock_err     (lock_err)
    );

    // x^8+x^6+x^5+x^4+1 Fibonacci LFSR
    always @(posedge clk) begin
        if (rst) model <= 8'h00;
        else if (lfsr_load) model <= lfsr_seed;
        else if (lfsr_en) model <= {model[6:0], model[7] ^ model[5] ^ model[4] ^ model[3]};
    end
    assign lfsr_q = force_zero ? 8'h00 : model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_load, input logic [15:0] val);
        exp_t e;
        e.is_load = is_load;
        e.val     = val;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] s, input logic [7:0] expect_seed);
        sw       = s;
        btn_load = 1'b1;
        push(1'b1, {8'h00, expect_seed});
        clk1();
        btn_load = 1'b0;
        clk1();
    endtask

    task automatic pulse_run();
        btn_run = 1'b1;
        clk1();
        btn_run = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_running"}, 32'(running), 32'h0);
        chk({tag, "_load"}, 32'(lfsr_load), 32'h0);
        chk({tag, "_en"}, 32'(lfsr_en), 32'h0);
        chk({tag, "_seed"}, 32'(lfsr_seed), 32'h01);
        chk({tag, "_step_cnt"}, 32'(step_cnt), 32'h0);
        chk({tag, "_period"}, 32'(period), 32'h0);
        chk({tag, "_pvalid"}, 32'(period_valid), 32'h0);
        chk({tag, "_lock"}, 32'(lock_err), 32'h0);
    endtask

    // Monitor: every load or shift pulse must match the head of the expectation queue
    always @(negedge clk) begin
        exp_t e;
        if (!done && (lfsr_load || lfsr_en)) begin
            if (exp_q.size() == 0) begin
                chk(lfsr_load ? "unexpected_load" : "unexpected_en", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind_is_load", 32'(lfsr_load), 32'(e.is_load));
                if (lfsr_load) chk("load_seed", 32'(lfsr_seed), 32'(e.val));
                else chk("en_step_cnt", 32'(step_cnt), 32'(e.val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        bit run_ok;
        rst = 1'b1; tick = 1'b0; btn_load = 1'b0; btn_run = 1'b0; btn_step = 1'b0;
        sw = 8'h00; force_zero = 1'b0;
        clk1();
        clk1();
        rst = 1'b0;
        chk_reset_vals("reset");

        // Seed load
        do_load(8'hA5, 8'hA5);
        chk("seed_a5", 32'(lfsr_seed), 32'hA5);
        chk("seed_step_cnt", 32'(step_cnt), 32'h0);
        chk("seed_paused", 32'(running), 32'h0);

        // Zero seed substitution
        do_load(8'h00, 8'h01);
        chk("zero_seed", 32'(lfsr_seed), 32'h01);
        chk("zero_seed_lock", 32'(lock_err), 32'h0);

        // Single step: one shift on the first tick only
        btn_step = 1'b1;
        clk1();
        btn_step = 1'b0;
        clk1();
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1;
            if (t == 0) push(1'b0, 16'd0);
            clk1();
            tick = 1'b0;
            clk1();
        end
        chk("step_cnt_one", 32'(step_cnt), 32'h1);
        chk("step_back_pause", 32'(running), 32'h0);

        // Full period from seed 01
        do_load(8'h01, 8'h01);
        pulse_run();
        run_ok = 1'b1;
        for (int i = 0; i < 255; i++) begin
            tick = 1'b1;
            push(1'b0, 16'(i));
            run_ok &= running;
            clk1();
            tick = 1'b0;
            for (int k = 0; k < 3; k++) begin
                run_ok &= running;
                clk1();
            end
            if (i == 253) chk("pvalid_before_255", 32'(period_valid), 32'h0);
        end
        chk("running_throughout", 32'(run_ok), 32'h1);
        chk("period_255", 32'(period), 32'd255);
        chk("period_valid", 32'(period_valid), 32'h1);

        // Load beats run in the same cycle while in RUN, and suppresses the tick
        sw = 8'hA5; btn_load = 1'b1; btn_run = 1'b1; tick = 1'b1;
        push(1'b1, 16'hA5);
        clk1();
        btn_load = 1'b0; btn_run = 1'b0; tick = 1'b0;
        clk1();
        chk("prio_step_cnt", 32'(step_cnt), 32'h0);
        chk("prio_paused", 32'(running), 32'h0);
        chk("prio_pvalid_clr", 32'(period_valid), 32'h0);

        // Load aborts a pending step
        btn_step = 1'b1;
        clk1();
        btn_step = 1'b0;
        sw = 8'h3C; btn_load = 1'b1; tick = 1'b1;
        push(1'b1, 16'h3C);
        clk1();
        btn_load = 1'b0; tick = 1'b0;
        clk1();
        chk("abort_step_cnt", 32'(step_cnt), 32'h0);

        // Lock-up: LFSR reads zero after a shift
        pulse_run();
        tick = 1'b1;
        push(1'b0, 16'd0);
        clk1();
        tick = 1'b0;
        force_zero = 1'b1;
        clk1();
        force_zero = 1'b0;
        chk("lock_err_set", 32'(lock_err), 32'h1);
        chk("lock_paused", 32'(running), 32'h0);
        pulse_run();
        chk("lock_run_refused", 32'(running), 32'h0);
        btn_step = 1'b1;
        clk1();
        btn_step = 1'b0;
        tick = 1'b1;
        clk1();
        tick = 1'b0;
        clk1();
        chk("lock_step_refused", 32'(step_cnt), 32'h1);

        // Reset mid-RUN, with a tick in the reset cycle
        do_load(8'h5A, 8'h5A);
        chk("lock_cleared", 32'(lock_err), 32'h0);
        pulse_run();
        tick = 1'b1;
        push(1'b0, 16'd0);
        clk1();
        tick = 1'b0;
        clk1();
        rst = 1'b1; tick = 1'b1;
        clk1();
        rst = 1'b0; tick = 1'b0;
        chk_reset_vals("midrun_rst");

        clk1();
        clk1();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        done = 1'b1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
